// File: rtl/tia_missile_position_counter.sv
// TIA missile horizontal position counter.
// A free-running mod-PERIOD counter advanced by the motion clock (one count per pixel).
// The count and the NUSIZ copy/width bits are decoded into the missile serial graphics bit m.
// The counter is placed at PERIOD-1 on reset, so the next edge is the first pixel of the missile.
module tia_missile_position_counter #(
    parameter int unsigned PERIOD = 160
) (
    input  logic motck,
    input  logic missile_to_player_reset_bar,
    input  logic clkp,
    input  logic mec_bar,
    input  logic nz0_bar,
    input  logic nz1_bar,
    input  logic nz2_bar,
    input  logic nz4_bar,
    input  logic nz5_bar,
    input  logic missile_enable,
    input  logic missile_reset,
    input  logic missile_to_player_reset,
    output logic m
);

    localparam logic [7:0] LastCount = 8'(PERIOD - 1);
    // Threshold at or above which a +2 step wraps past the end of the line.
    localparam logic [7:0] WrapTwo   = 8'(PERIOD - 2);

    // The pixel-clock phase has no role in this block.
    logic unused_clkp;
    assign unused_clkp = clkp;

    logic [7:0] count_q;
    logic [7:0] count_d;

    // NUSIZ bits arrive inverted; restore true sense once here.
    logic [2:0] nz_copy;
    logic [1:0] nz_width;
    assign nz_copy  = {~nz2_bar, ~nz1_bar, ~nz0_bar};
    assign nz_width = {~nz5_bar, ~nz4_bar};

    // Next count: reset strobes win, HMOVE extra clock adds a second count, else plain advance.
    always_comb begin
        count_d = count_q;
        if (missile_reset || missile_to_player_reset) begin
            count_d = LastCount;
        end else if (!mec_bar) begin
            if (count_q >= WrapTwo) begin
                count_d = count_q - WrapTwo;
            end else begin
                count_d = count_q + 8'd2;
            end
        end else begin
            if (count_q >= LastCount) begin
                count_d = 8'd0;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    // Position register; async RESMP lock parks it at the last count.
    always_ff @(posedge motck or negedge missile_to_player_reset_bar) begin
        if (!missile_to_player_reset_bar) begin
            count_q <= LastCount;
        end else begin
            count_q <= count_d;
        end
    end

    logic       copy16;
    logic       copy32;
    logic       copy64;
    logic [3:0] width;

    // Extra copy origins besides the always-present copy at count 0.
    always_comb begin
        copy16 = 1'b0;
        copy32 = 1'b0;
        copy64 = 1'b0;
        unique case (nz_copy)
            3'b001: copy16 = 1'b1;
            3'b010: copy32 = 1'b1;
            3'b011: begin
                copy16 = 1'b1;
                copy32 = 1'b1;
            end
            3'b100: copy64 = 1'b1;
            3'b110: begin
                copy32 = 1'b1;
                copy64 = 1'b1;
            end
            default: begin
                // 000, 101 and 111 show the single copy only.
                copy16 = 1'b0;
                copy32 = 1'b0;
                copy64 = 1'b0;
            end
        endcase
    end

    // Missile width in counts.
    always_comb begin
        width = 4'd1;
        unique case (nz_width)
            2'b00:   width = 4'd1;
            2'b01:   width = 4'd2;
            2'b10:   width = 4'd4;
            2'b11:   width = 4'd8;
            default: width = 4'd1;
        endcase
    end

    // True when c lies in [s, s+w-1]; extended to 9 bits so the end bound cannot wrap.
    function automatic logic in_window(input logic [7:0] c, input logic [7:0] s,
                                       input logic [3:0] w);
        logic [8:0] c_ext;
        logic [8:0] end_ext;
        c_ext   = {1'b0, c};
        end_ext = {1'b0, s} + {5'd0, w};
        return (c >= s) && (c_ext < end_ext);
    endfunction

    logic hit0;
    logic hit16;
    logic hit32;
    logic hit64;
    logic hit_any;

    // Graphics decode: combinational from the count so NUSIZ changes act immediately.
    always_comb begin
        hit0    = in_window(count_q, 8'd0, width);
        hit16   = copy16 && in_window(count_q, 8'd16, width);
        hit32   = copy32 && in_window(count_q, 8'd32, width);
        hit64   = copy64 && in_window(count_q, 8'd64, width);
        hit_any = hit0 || hit16 || hit32 || hit64;
        m       = missile_enable && !missile_to_player_reset && missile_to_player_reset_bar
                  && hit_any;
    end

endmodule

// File: tb/tb_tia_missile_position_counter.sv
// Scoreboard bench for the missile position counter: stimulus pushes the expected m after each
// motck edge into a queue; a monitor pops and compares on the following falling edge.
module tb_tia_missile_position_counter;

    logic motck = 1'b0;
    logic rst_n = 1'b1;
    logic clkp;
    logic mec_bar = 1'b1;
    logic nz0_bar = 1'b1;
    logic nz1_bar = 1'b1;
    logic nz2_bar = 1'b1;
    logic nz4_bar = 1'b1;
    logic nz5_bar = 1'b1;
    logic en = 1'b1;
    logic mr = 1'b0;
    logic mtpr = 1'b0;
    logic m;

    always #5 motck = ~motck;
    assign clkp = ~motck;

    tia_missile_position_counter #(.PERIOD(160)) dut (
        .motck                       (motck),
        .missile_to_player_reset_bar (rst_n),
        .clkp                        (clkp),
        .mec_bar                     (mec_bar),
        .nz0_bar                     (nz0_bar),
        .nz1_bar                     (nz1_bar),
        .nz2_bar                     (nz2_bar),
        .nz4_bar                     (nz4_bar),
        .nz5_bar                     (nz5_bar),
        .missile_enable              (en),
        .missile_reset               (mr),
        .missile_to_player_reset     (mtpr),
        .m                           (m)
    );

    int    checks   = 0;
    int    failures = 0;
    bit    exp_q[$];
    int    exp_c[$];
    int    c_ref    = 159;
    string phase    = "reset";
    bit    mon_exp;
    int    mon_c;

    // Hand-written copy origins per NUSIZ copy code; -1 marks an unused slot.
    int starts [8][3] = '{
        '{0, -1, -1}, '{0, 16, -1}, '{0, 32, -1}, '{0, 16, 32},
        '{0, 64, -1}, '{0, -1, -1}, '{0, 32, 64}, '{0, -1, -1}
    };

    function automatic bit expect_m();
        int code;
        int w;
        bit hit;
        code = {!nz2_bar, !nz1_bar, !nz0_bar};
        w    = 1 << int'({!nz5_bar, !nz4_bar});
        hit  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (starts[code][k] >= 0 && c_ref >= starts[code][k] && c_ref < starts[code][k] + w)
                hit = 1'b1;
        end
        return en && !mtpr && rst_n && hit;
    endfunction

    // One motck edge. async_rst pulls the reset low just after the edge, before the sample.
    task automatic step(input bit async_rst);
        if (!rst_n || mr || mtpr) c_ref = 159;
        else if (!mec_bar)        c_ref = (c_ref + 2) % 160;
        else                      c_ref = (c_ref + 1) % 160;
        exp_q.push_back(async_rst ? 1'b0 : expect_m());
        exp_c.push_back(c_ref);
        @(posedge motck);
        if (async_rst) begin
            #1;
            rst_n = 1'b0;
            c_ref = 159;
        end
        @(negedge motck);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic set_nz(input int code);
        {nz2_bar, nz1_bar, nz0_bar} = ~3'(code);
    endtask

    // Monitor: compare m against the scoreboard on every falling edge with a pending entry.
    initial begin
        forever begin
            @(negedge motck);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_c   = exp_c.pop_front();
                checks++;
                if (m !== mon_exp) begin
                    failures++;
                    $display("FAIL %s m at count %0d: got %b expected %b", phase, mon_c, m,
                             mon_exp);
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        @(negedge motck);
        #1;
        // Held in reset: m stays 0.
        run(2);

        phase = "powerup";
        rst_n = 1'b1;
        run(480);

        for (int code = 1; code < 8; code++) begin
            phase = $sformatf("nz%0d", code);
            set_nz(code);
            run(160);
        end

        phase = "width8";
        set_nz(0);
        {nz5_bar, nz4_bar} = 2'b00;
        run(160);
        phase = "width2";
        {nz5_bar, nz4_bar} = 2'b10;
        run(160);
        {nz5_bar, nz4_bar} = 2'b11;

        phase = "resm";
        set_nz(3);
        run(50);
        mr = 1'b1;
        step(1'b0);
        mr = 1'b0;
        run(200);

        phase = "hmove";
        mec_bar = 1'b0;
        run(4);
        mec_bar = 1'b1;
        run(320);

        phase = "async";
        set_nz(0);
        for (int i = 0; i < 200 && c_ref != 159; i++) step(1'b0);
        step(1'b1);
        step(1'b0);
        rst_n = 1'b1;
        run(170);

        phase = "enable";
        en = 1'b0;
        run(160);
        en = 1'b1;
        run(160);

        phase = "resmp";
        run(20);
        mtpr = 1'b1;
        run(3);
        mtpr = 1'b0;
        run(40);

        phase = "resm_vs_hmove";
        mr = 1'b1;
        mec_bar = 1'b0;
        step(1'b0);
        mr = 1'b0;
        mec_bar = 1'b1;
        run(20);

        phase = "drain";
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge motck);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
